// File: rtl/ro_block_n.sv
// ro_block_n: N-channel event readout scheduler, edge capture into pending latches
// drained by a free-running time-division scan with a gray-coded slot output.
module ro_block_n #(
  parameter int N_CH   = 8,
  parameter int SLOT_W = $clog2(N_CH)
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              en,
  input  logic              ovf_clr,
  input  logic [N_CH-1:0]   in_eve,
  input  logic [N_CH-1:0]   in_pol_eve,
  output logic              out_valid,
  output logic              out_eve,
  output logic              out_pol_eve,
  output logic [SLOT_W-1:0] out_ch,
  output logic [SLOT_W-1:0] gray_slot,
  output logic [N_CH-1:0]   overflow
);
  logic [SLOT_W-1:0] slot_q, slot_d, ch_q, ch_d, gray_q, gray_d, slot_nx;
  logic [N_CH-1:0]   prev_q, pend_q, pend_d, pol_q, pol_d, ovf_q, ovf_d;
  logic [N_CH-1:0]   rise, rd, accept;
  logic              valid_q, valid_d, opol_q, opol_d;
  always_comb begin
    slot_nx = slot_q + SLOT_W'(1);
    rd      = en ? N_CH'(1) << slot_q : '0;
    rise    = in_eve & ~prev_q;
    // a rise on the channel being read this cycle refills the latch instead of overflowing
    accept  = rise & (~pend_q | rd);
    pend_d  = (pend_q & ~rd) | rise;
    pol_d   = (pol_q & ~accept) | (in_pol_eve & accept);
    ovf_d   = (ovf_clr ? '0 : ovf_q) | (rise & ~accept);
    slot_d  = en ? slot_nx : slot_q;
    gray_d  = en ? slot_nx ^ (slot_nx >> 1) : gray_q;
    ch_d    = en ? slot_q : ch_q;
    valid_d = en & pend_q[slot_q];
    opol_d  = en & pend_q[slot_q] & pol_q[slot_q];
  end
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      slot_q  <= '0;
      ch_q    <= '0;
      gray_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      opol_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      gray_q  <= gray_d;
      prev_q  <= in_eve;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      opol_q  <= opol_d;
    end
  end
  assign out_valid   = valid_q;
  assign out_eve     = valid_q;
  assign out_pol_eve = opol_q;
  assign out_ch      = ch_q;
  assign gray_slot   = gray_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_ro_block_n.sv
// tb_ro_block_n: scoreboard bench for ro_block_n at N_CH = 8, 2 and 32 sharing one clock/reset.
module tb_ro_block_n;
  logic clk = 0, rstb = 0, en = 0, ovf_clr = 0;
  logic [7:0]  ev8 = 0, pol8 = 0, ov8;
  logic        v8, e8, p8;
  logic [2:0]  ch8, g8;
  logic [1:0]  ev2 = 0, pol2 = 0, ov2;
  logic        v2, e2, p2, ch2, g2;
  logic [31:0] ev32 = 0, pol32 = 0, ov32;
  logic        v32, e32, p32;
  logic [4:0]  ch32, g32;
  int checks = 0, errors = 0;
  typedef struct {int ch; logic pol; int lat;} exp_t;
  exp_t sb[$], sb2[$], sb32[$];

  always #5 clk = ~clk;

  ro_block_n #(.N_CH(8)) d8 (
    .clk_master(clk), .rstb(rstb), .en(en), .ovf_clr(ovf_clr),
    .in_eve(ev8), .in_pol_eve(pol8), .out_valid(v8), .out_eve(e8),
    .out_pol_eve(p8), .out_ch(ch8), .gray_slot(g8), .overflow(ov8));
  ro_block_n #(.N_CH(2)) d2 (
    .clk_master(clk), .rstb(rstb), .en(en), .ovf_clr(ovf_clr),
    .in_eve(ev2), .in_pol_eve(pol2), .out_valid(v2), .out_eve(e2),
    .out_pol_eve(p2), .out_ch(ch2), .gray_slot(g2), .overflow(ov2));
  ro_block_n #(.N_CH(32)) d32 (
    .clk_master(clk), .rstb(rstb), .en(en), .ovf_clr(ovf_clr),
    .in_eve(ev32), .in_pol_eve(pol32), .out_valid(v32), .out_eve(e32),
    .out_pol_eve(p32), .out_ch(ch32), .gray_slot(g32), .overflow(ov32));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstb = 0; en = 0; ovf_clr = 0;
    ev8 = 0; pol8 = 0; ev2 = 0; pol2 = 0; ev32 = 0; pol32 = 0;
    tick;
    tick;
    rstb = 1;
  endtask

  task automatic test_reset;
    logic [2:0] pg, gx;
    do_reset;
    en = 1;
    ev8[2] = 1; tick;
    ev8[2] = 0; ev8[6] = 1; tick;
    ev8[6] = 0; tick;
    checks++;
    if (v8 !== 1'b1 || ch8 !== 3'd2) begin
      errors++; $display("FAIL pre_reset_read valid=%0b ch=%0d expected valid=1 ch=2", v8, ch8);
    end
    #2 rstb = 0;
    #1;
    checks++;
    if ({v8, e8, p8, ch8, g8, ov8} !== '0) begin
      errors++; $display("FAIL async_reset v=%0b e=%0b p=%0b ch=%0d g=%0d ovf=%h expected all 0", v8, e8, p8, ch8, g8, ov8);
    end
    tick;
    rstb = 1;
    pg = g8;
    for (int c = 1; c <= 9; c++) begin
      tick;
      gx = 3'(c);
      checks++;
      if (ch8 !== 3'(c - 1) || g8 !== (gx ^ (gx >> 1)) || v8 !== 1'b0 || $countones(g8 ^ pg) != 1) begin
        errors++; $display("FAIL scan_step c=%0d ch=%0d gray=%0d valid=%0b expected ch=%0d gray=%0d valid=0 one-bit step",
                           c, ch8, g8, v8, 3'(c - 1), gx ^ (gx >> 1));
      end
      pg = g8;
    end
  endtask

  task automatic test_single;
    exp_t x;
    do_reset;
    en = 1;
    tick; tick;
    ev8[5] = 1; pol8[5] = 1; tick;
    ev8[5] = 0; pol8[5] = 0;
    sb.push_back('{ch: 5, pol: 1'b1, lat: 3});
    for (int c = 1; c <= 16; c++) begin
      tick;
      checks++;
      if (e8 !== v8 || (!v8 && p8 !== 1'b0)) begin
        errors++; $display("FAIL single_outs c=%0d eve=%0b valid=%0b pol=%0b expected eve=valid, pol 0 when idle", c, e8, v8, p8);
      end
      if (v8) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL single_extra c=%0d ch=%0d expected no emission", c, ch8);
        end else begin
          x = sb.pop_front();
          if (ch8 !== 3'(x.ch) || p8 !== x.pol || c != x.lat) begin
            errors++; $display("FAIL single_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch8, p8, x.lat, x.ch, x.pol);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL single_missing left=%0d expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_overflow;
    exp_t x;
    do_reset;
    en = 1;
    ev8[3] = 1; pol8[3] = 0; tick;
    ev8[3] = 0; tick;
    ev8[3] = 1; pol8[3] = 1; tick;
    ev8 = 0; pol8 = 0;
    checks++;
    if (ov8 !== 8'h08) begin
      errors++; $display("FAIL ovf_set ovf=%h expected 08", ov8);
    end
    sb.push_back('{ch: 3, pol: 1'b0, lat: 1});
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (v8) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL ovf_extra c=%0d ch=%0d pol=%0b expected no emission", c, ch8, p8);
        end else begin
          x = sb.pop_front();
          if (ch8 !== 3'(x.ch) || p8 !== x.pol || c != x.lat) begin
            errors++; $display("FAIL ovf_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch8, p8, x.lat, x.ch, x.pol);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || ov8 !== 8'h08) begin
      errors++; $display("FAIL ovf_sticky left=%0d ovf=%h expected 0 left ovf=08", sb.size(), ov8);
    end
    sb.delete();
    ovf_clr = 1; tick;
    ovf_clr = 0;
    checks++;
    if (ov8 !== 8'h00) begin
      errors++; $display("FAIL ovf_clear ovf=%h expected 00", ov8);
    end
  endtask

  task automatic test_same_cycle;
    exp_t x;
    do_reset;
    en = 1;
    ev8[0] = 1; pol8[0] = 1; tick;
    ev8[0] = 0; pol8[0] = 0;
    sb.push_back('{ch: 0, pol: 1'b1, lat: 8});
    sb.push_back('{ch: 0, pol: 1'b0, lat: 16});
    for (int c = 1; c <= 20; c++) begin
      ev8[0] = (c == 8);
      tick;
      if (v8) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL same_extra c=%0d ch=%0d expected no emission", c, ch8);
        end else begin
          x = sb.pop_front();
          if (ch8 !== 3'(x.ch) || p8 !== x.pol || c != x.lat) begin
            errors++; $display("FAIL same_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch8, p8, x.lat, x.ch, x.pol);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || ov8 !== 8'h00) begin
      errors++; $display("FAIL same_final left=%0d ovf=%h expected 0 left ovf=00", sb.size(), ov8);
    end
    sb.delete();
  endtask

  task automatic test_enable;
    exp_t x;
    do_reset;
    en = 1;
    tick; tick; tick;
    en = 0;
    pol8[1] = 1; pol8[6] = 0;
    for (int c = 1; c <= 20; c++) begin
      ev8[1] = (c == 3);
      ev8[6] = (c == 10);
      tick;
      checks++;
      if (v8 !== 1'b0 || ch8 !== 3'd2 || g8 !== 3'd2) begin
        errors++; $display("FAIL en_hold c=%0d valid=%0b ch=%0d gray=%0d expected valid=0 ch=2 gray=2", c, v8, ch8, g8);
      end
    end
    ev8 = 0;
    en = 1;
    sb.push_back('{ch: 6, pol: 1'b0, lat: 4});
    sb.push_back('{ch: 1, pol: 1'b1, lat: 7});
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (v8) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL en_extra c=%0d ch=%0d expected no emission", c, ch8);
        end else begin
          x = sb.pop_front();
          if (ch8 !== 3'(x.ch) || p8 !== x.pol || c != x.lat) begin
            errors++; $display("FAIL en_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch8, p8, x.lat, x.ch, x.pol);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL en_missing left=%0d expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_sweep;
    exp_t x;
    logic [4:0] gx;
    do_reset;
    en = 1;
    pol2[1] = 1; pol32[5] = 1;
    sb2.push_back('{ch: 1, pol: 1'b1, lat: 4});
    sb32.push_back('{ch: 5, pol: 1'b1, lat: 38});
    for (int c = 1; c <= 40; c++) begin
      ev2[1] = (c == 2);
      ev32[5] = (c == 6);
      tick;
      gx = 5'(c);
      checks++;
      if (ch2 !== 1'(c - 1) || g2 !== 1'(c) || ch32 !== 5'(c - 1) || g32 !== (gx ^ (gx >> 1))) begin
        errors++; $display("FAIL sweep_wrap c=%0d ch2=%0d g2=%0d ch32=%0d g32=%0d expected %0d %0d %0d %0d",
                           c, ch2, g2, ch32, g32, 1'(c - 1), 1'(c), 5'(c - 1), gx ^ (gx >> 1));
      end
      if (v2) begin
        checks++;
        if (sb2.size() == 0) begin
          errors++; $display("FAIL sweep2_extra c=%0d ch=%0d expected no emission", c, ch2);
        end else begin
          x = sb2.pop_front();
          if (ch2 !== 1'(x.ch) || p2 !== x.pol || e2 !== 1'b1 || c != x.lat) begin
            errors++; $display("FAIL sweep2_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch2, p2, x.lat, x.ch, x.pol);
          end
        end
      end
      if (v32) begin
        checks++;
        if (sb32.size() == 0) begin
          errors++; $display("FAIL sweep32_extra c=%0d ch=%0d expected no emission", c, ch32);
        end else begin
          x = sb32.pop_front();
          if (ch32 !== 5'(x.ch) || p32 !== x.pol || e32 !== 1'b1 || c != x.lat) begin
            errors++; $display("FAIL sweep32_emit c=%0d ch=%0d pol=%0b expected c=%0d ch=%0d pol=%0b", c, ch32, p32, x.lat, x.ch, x.pol);
          end
        end
      end
    end
    checks++;
    if (sb2.size() != 0 || sb32.size() != 0 || ov2 !== 2'b0 || ov32 !== 32'b0) begin
      errors++; $display("FAIL sweep_final left2=%0d left32=%0d ovf2=%h ovf32=%h expected 0 0 0 0", sb2.size(), sb32.size(), ov2, ov32);
    end
    sb2.delete();
    sb32.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_same_cycle;
    test_enable;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ro_block_n.md
# ro_block_n

Parametrised N-channel readout scheduler for the cochlea event path. Replaces one-per-channel gray-gated tristate readout cells with a single registered time-division multiplexer. Each channel's `in_eve` rising edge and its polarity `in_pol_eve` are captured into a pending latch, then emitted in that channel's slot of a free-running gray-coded scan. Sits between the per-channel comparator/event logic and the chip-level serial readout pins.

## Interface
- `N_CH`, default 8: channel count; must be a power of 2, at least 2.
- `SLOT_W`, default `$clog2(N_CH)`: slot/channel index width; derived, not overridden.
- `clk_master`  in  1  core clock; all state updates on its rising edge.
- `rstb`  in  1  reset; asynchronous and active-low.
- `en`  in  1  scan enable; 0 freezes the slot counter and suppresses readout, but capture continues.
- `ovf_clr`  in  1  synchronous clear of all `overflow` bits.
- `in_eve`  in  N_CH  per-channel event level, synchronous to `clk_master`.
- `in_pol_eve`  in  N_CH  per-channel polarity, sampled on the same edge as the `in_eve` rising edge.
- `out_valid`  out  1  registered; 1 for one cycle when a pending event is emitted.
- `out_eve`  out  1  registered; equals `out_valid`; driven 0 otherwise, with no tristate.
- `out_pol_eve`  out  1  registered polarity of the emitted event; 0 when `out_valid`=0.
- `out_ch`  out  SLOT_W  registered binary index of the slot just scanned, valid or not.
- `gray_slot`  out  SLOT_W  registered gray code of the current slot: `slot ^ (slot>>1)`.
- `overflow`  out  N_CH  sticky per-channel flag: an event was dropped.

## Operation
- Internal regs:
  - binary `slot` (SLOT_W).
  - `prev_eve`, `pend`, `pol` (each N_CH).
  - output regs.
- Edge detect: `rise[i] = in_eve[i] & ~prev_eve[i]`. `prev_eve <= in_eve` every cycle, independent of `en`.
- Read of channel s (when `en`=1 and s=`slot`): `out_ch <= s`, `out_valid <= pend[s]`, `out_eve <= pend[s]`, `out_pol_eve <= pend[s] & pol[s]`. Then `pend[s] <= 0` if read, `slot <= slot+1`.
- Slot counter wraps from `N_CH-1` to 0; `gray_slot <= gray(slot+1)` whenever `slot` advances.
- Capture on `rise[i]`:
  - If `pend[i]`=0, or if it is being cleared this same cycle by a read: `pend[i] <= 1`, `pol[i] <= in_pol_eve[i]`.
  - If `pend[i]`=1 and not being read this cycle: event dropped, `pol[i]` unchanged (first event wins), `overflow[i] <= 1`.
- Simultaneous read and rise on the same channel: the old event is emitted and the new event becomes pending. No overflow.
- `en`=0: `slot` and `gray_slot` hold, `out_valid`/`out_eve`/`out_pol_eve` <= 0, `out_ch` holds. Capture and overflow logic keep running.
- `ovf_clr`=1 clears all `overflow` bits. A set in the same cycle wins (flag remains 1).
- Reset (`rstb`=0, any time, including mid-scan): all regs 0. That gives `slot`=0, `gray_slot`=0, `out_ch`=0, all outputs 0, and all pending events discarded. The first edge after release reads slot 0 if `en`=1.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Capture latency: a rise sampled at edge k sets `pend` at edge k. The earliest emission is at edge k+1, if `slot` is i just before k+1.
- Worst-case event-to-`out_valid` latency: N_CH cycles with `en` held 1, plus any cycles with `en`=0.
- Each slot lasts one cycle; a full scan is N_CH cycles; each channel is read at most once per scan.
- Max sustained rate per channel: one event per N_CH cycles without overflow.
- `gray_slot` changes by exactly one bit per advance, including the wrap.

## Test plan
- Reset and idle. Apply `rstb`=0 mid-scan with `pend` set. Required: all outputs 0 immediately. After release with `en`=1, `out_ch` steps 0,1,..,7,0 and `gray_slot` steps 0,1,3,2,6,7,5,4,0. Check one bit changes per step.
- Single event. N_CH=8, rise on ch5 with `in_pol_eve`=1 while `slot`=2. Required: `out_valid`=1, `out_ch`=5, `out_pol_eve`=1 exactly once, 3 cycles later, then `pend[5]`=0.
- Overflow. Two rises on ch3, 2 cycles apart, neither in ch3's slot; first polarity 0, second 1. Required: one emission with `out_pol_eve`=0, `overflow[3]`=1. `ovf_clr` pulse returns it to 0.
- Same-cycle read and rise on ch0. Required: the old event is emitted, the new one is emitted in the next scan (8 cycles later), and `overflow[0]` stays 0.
- Enable gating. Hold `en`=0 for 20 cycles while ch1 and ch6 rise. Required: no `out_valid` and `slot` frozen. After `en`=1, both channels are emitted in slot order within 8 cycles.
- Parameter sweep. Repeat scenario 2 at N_CH=2 and N_CH=32. Required: wrap at N_CH-1 and worst-case latency of N_CH cycles.
